pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS pipeline CPU.
- Carries one opaque datapath payload and one control bundle per beat, with valid/ready handshake, an optional 2-entry skid buffer, stall hold, flush-to-bubble, and saturating stall/flush statistics counters.
- Sits between any two pipeline stages; hazard/exception units drive stall and flush exactly as they do today.

---
 rtl/pipe_stage_reg.sv | 170 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries one payload + control bundle per beat between two pipeline stages.
// Latency: 1 cycle from an accepted beat into an empty stage to out_*; holds up to 2 beats when SKID=1.
// Backpressure: valid/ready on both sides. Stall freezes the stage, flush discards all held beats.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_data/in_ctrl carry the beat
//   out_valid/out_ready downstream handshake; out_data/out_ctrl show the head beat
//   stall, flush        hazard hold and discard-to-bubble from the hazard/exception units
//   occupancy           number of held beats (0..2)
//   stall_cnt/flush_cnt saturating statistics counters
module pipe_stage_reg #(
   parameter int                 DATA_W      = 160,
   parameter int                 CTRL_W      = 32,
   parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
   parameter int                 SKID        = 1,
   parameter int                 CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // Head (main) entry drives the outputs; skid entry catches the beat that
   // arrives while the head is blocked downstream.
   logic              main_vld_q, main_vld_d;
   logic [DATA_W-1:0] main_dat_q, main_dat_d;
   logic [CTRL_W-1:0] main_ctl_q, main_ctl_d;
   logic              skid_vld_q, skid_vld_d;
   logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
   logic [CTRL_W-1:0] skid_ctl_q, skid_ctl_d;

   // Low during reset and for the edge that releases it, so in_ready only
   // rises on the first clock edge after reset deasserts.
   logic              rdy_en_q;

   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              emit;
   logic              accept;
   logic              stall_inc;
   logic              flush_inc;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   assign emit = main_vld_q & out_ready & ~stall;

   // With a skid entry the ready path depends only on registered state plus
   // stall; without one it must look through to out_ready.
   generate
      if (SKID != 0) begin : g_rdy_skid
         assign in_ready = rdy_en_q & ~skid_vld_q & ~stall;
      end else begin : g_rdy_noskid
         assign in_ready = rdy_en_q & (~main_vld_q | (out_ready & ~stall)) & ~stall;
      end
   endgenerate

   assign accept = in_valid & in_ready;

   always_comb begin
      main_vld_d = main_vld_q;
      main_dat_d = main_dat_q;
      main_ctl_d = main_ctl_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      skid_ctl_d = skid_ctl_q;

      if (flush) begin
         // Data registers keep their contents; only valid and control are
         // scrubbed so the bubble is a guaranteed no-op downstream.
         main_vld_d = 1'b0;
         main_ctl_d = CTRL_BUBBLE;
         skid_vld_d = 1'b0;
      end else if (!stall) begin
         if (!main_vld_q || emit) begin
            if (skid_vld_q) begin
               // Older beat in skid advances first to keep FIFO order.
               main_vld_d = 1'b1;
               main_dat_d = skid_dat_q;
               main_ctl_d = skid_ctl_q;
               skid_vld_d = accept;
               if (accept) begin
                  skid_dat_d = in_data;
                  skid_ctl_d = in_ctrl;
               end
            end else if (accept) begin
               main_vld_d = 1'b1;
               main_dat_d = in_data;
               main_ctl_d = in_ctrl;
            end else begin
               main_vld_d = 1'b0;
               main_ctl_d = CTRL_BUBBLE;
            end
         end else if (accept) begin
            // Head blocked: in_ready guarantees the skid entry is free here.
            skid_vld_d = 1'b1;
            skid_dat_d = in_data;
            skid_ctl_d = in_ctrl;
         end
      end

      // Single-entry build: the skid flops are held constant and drop out.
      if (SKID == 0) begin
         skid_vld_d = 1'b0;
         skid_dat_d = '0;
         skid_ctl_d = CTRL_BUBBLE;
      end
   end

   // Stall together with flush counts as a flush only.
   assign stall_inc = stall & ~flush & main_vld_q;
   assign flush_inc = flush & (main_vld_q | skid_vld_q);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_vld_q  <= 1'b0;
         main_dat_q  <= '0;
         main_ctl_q  <= CTRL_BUBBLE;
         skid_vld_q  <= 1'b0;
         skid_dat_q  <= '0;
         skid_ctl_q  <= CTRL_BUBBLE;
         rdy_en_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         main_vld_q  <= main_vld_d;
         main_dat_q  <= main_dat_d;
         main_ctl_q  <= main_ctl_d;
         skid_vld_q  <= skid_vld_d;
         skid_dat_q  <= skid_dat_d;
         skid_ctl_q  <= skid_ctl_d;
         rdy_en_q    <= 1'b1;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign out_valid = main_vld_q;
   assign out_data  = main_dat_q;
   // Masked so a bubble never exposes stale control downstream.
   assign out_ctrl  = main_vld_q ? main_ctl_q : CTRL_BUBBLE;
   assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int              DW   = 16;
   localparam int              CW   = 8;
   localparam int              CNTW = 4;
   localparam logic [CW-1:0]   BUB  = 8'hA5;
   localparam int              SMAX = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          out_ready = 1'b0;

   // Index 0: SKID=1 instance, index 1: SKID=0 instance; both see the same inputs.
   logic            ir  [2];
   logic            ov  [2];
   logic [DW-1:0]   od  [2];
   logic [CW-1:0]   oc  [2];
   logic [1:0]      occ [2];
   logic [CNTW-1:0] sc  [2];
   logic [CNTW-1:0] fc  [2];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .SKID(1), .CNT_W(CNTW)) u_dut_skid (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
      .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .out_ctrl(oc[0]), .occupancy(occ[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .SKID(0), .CNT_W(CNTW)) u_dut_single (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
      .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .out_ctrl(oc[1]), .occupancy(occ[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a small FIFO (array + count) per instance plus counters.
   int            m_n  [2];
   logic [DW-1:0] m_d  [2][2];
   logic [CW-1:0] m_c  [2][2];
   int            m_sc [2];
   int            m_fc [2];
   bit            m_live = 1'b0;

   function automatic bit m_rdy(input int k);
      if (!m_live || stall) return 1'b0;
      if (k == 0) return (m_n[0] < 2);
      return (m_n[1] == 0) || out_ready;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= SMAX) ? SMAX : v + 1;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_n[k]  = 0;
         m_sc[k] = 0;
         m_fc[k] = 0;
      end
      m_live = 1'b0;
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("in_ready[%0d]", k), ir[k], m_rdy(k));
         chk($sformatf("out_valid[%0d]", k), ov[k], m_n[k] > 0);
         chk($sformatf("occupancy[%0d]", k), occ[k], m_n[k]);
         chk($sformatf("out_ctrl[%0d]", k), oc[k], (m_n[k] > 0) ? m_c[k][0] : BUB);
         if (m_n[k] > 0) chk($sformatf("out_data[%0d]", k), od[k], m_d[k][0]);
         chk($sformatf("stall_cnt[%0d]", k), sc[k], m_sc[k]);
         chk($sformatf("flush_cnt[%0d]", k), fc[k], m_fc[k]);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit rdy;
         bit emit;
         bit acc;
         rdy = m_rdy(k);
         if (flush) begin
            if (m_n[k] > 0) m_fc[k] = sat_inc(m_fc[k]);
            m_n[k] = 0;
         end else if (stall) begin
            if (m_n[k] > 0) m_sc[k] = sat_inc(m_sc[k]);
         end else begin
            emit = (m_n[k] > 0) && out_ready;
            acc  = in_valid && rdy;
            if (emit) begin
               m_d[k][0] = m_d[k][1];
               m_c[k][0] = m_c[k][1];
               m_n[k]--;
            end
            if (acc) begin
               m_d[k][m_n[k]] = in_data;
               m_c[k][m_n[k]] = in_ctrl;
               m_n[k]++;
            end
         end
      end
      m_live = 1'b1;
   endtask

   // One clock cycle: called at posedge+1, drives inputs, checks before the
   // next edge, advances the model, returns at posedge+1.
   task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] ct,
                      input logic st, input logic fl, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = ct;
      stall     = st;
      flush     = fl;
      out_ready = ordy;
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Reset asserted between edges; outputs must clear immediately.
   task automatic rst_mid();
      #2;
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_out_valid[%0d]", k), ov[k], 0);
         chk($sformatf("rst_out_ctrl[%0d]", k), oc[k], BUB);
         chk($sformatf("rst_out_data[%0d]", k), od[k], 0);
         chk($sformatf("rst_occupancy[%0d]", k), occ[k], 0);
         chk($sformatf("rst_stall_cnt[%0d]", k), sc[k], 0);
         chk($sformatf("rst_flush_cnt[%0d]", k), fc[k], 0);
         chk($sformatf("rst_in_ready[%0d]", k), ir[k], 0);
      end
      model_clear();
      in_valid  = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all();
      @(posedge clk);
      #1;
      m_live = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      model_clear();
      @(posedge clk);
      #1;
      rst_mid();

      // Stream 1..4 with downstream always ready.
      for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), CW'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      repeat (2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Backpressure: offer A, B, C while blocked, then release.
      cyc(1'b1, 16'h000A, 8'h0A, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h000B, 8'h0B, 1'b0, 1'b0, 1'b0);
      chk("bp_full_in_ready", ir[0], 0);
      cyc(1'b1, 16'h000C, 8'h0C, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h000C, 8'h0C, 1'b0, 1'b0, 1'b1);
      repeat (4) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Stall holds a valid beat for three cycles.
      rst_mid();
      cyc(1'b1, 16'h0005, 8'h05, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 16'h0006, 8'h06, 1'b1, 1'b0, 1'b1);
      chk("stall_cnt_3", sc[0], 3);
      chk("stall_hold_data", od[0], 16'h0005);
      repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Flush at full occupancy with a beat offered, then flush while empty.
      rst_mid();
      cyc(1'b1, 16'h00A1, 8'h21, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h00B2, 8'h32, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h00C3, 8'h43, 1'b0, 1'b1, 1'b0);
      chk("flush_cnt_1", fc[0], 1);
      chk("flush_out_ctrl", oc[0], BUB);
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
      chk("flush_empty_cnt", fc[0], 1);
      repeat (2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Counter saturation.
      rst_mid();
      cyc(1'b1, 16'h0077, 8'h77, 1'b0, 1'b0, 1'b0);
      repeat (20) cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      chk("stall_cnt_sat", sc[0], SMAX);
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Reset while holding two beats.
      cyc(1'b1, 16'h0111, 8'h11, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h0222, 8'h22, 1'b0, 1'b0, 1'b0);
      rst_mid();

      // Randomized traffic with an extra mid-stream reset.
      for (int i = 0; i < 500; i++) begin
         logic iv, st, fl, ordy;
         iv   = ($urandom_range(0, 3) != 0);
         st   = ($urandom_range(0, 7) == 0);
         fl   = ($urandom_range(0, 19) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         cyc(iv, DW'($urandom), CW'($urandom), st, fl, ordy);
         if (i == 250) rst_mid();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
